// File: rtl/shift_rows_stream_if.sv
// Beat-level handshake bundle for shift_rows_stream: upstream beat in, permuted beat out.
// The DUT takes the slave view; a producer/consumer pair takes the master view.
interface shift_rows_stream_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_inv;
    logic [TAG_W-1:0]    in_tag;
    logic [32*NB-1:0]    in_state;
    logic                out_valid;
    logic                out_ready;
    logic [TAG_W-1:0]    out_tag;
    logic [32*NB-1:0]    out_state;

    modport master (
        output in_valid, in_inv, in_tag, in_state, out_ready,
        input  in_ready, out_valid, out_tag, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_tag, in_state, out_ready,
        output in_ready, out_valid, out_tag, out_state
    );
endinterface

// File: rtl/shift_rows_stream.sv
// Rijndael (Inv)ShiftRows for NB=4/6/8 with tag sideband; 1-cycle latency into a 2-entry output buffer.
// Backpressure: in_ready drops only when both entries are held, independent of out_ready.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    shift_rows_stream_if.slave bus
);
    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8) || TAG_W < 1) begin : g_bad_param
            $error("shift_rows_stream: NB must be 4, 6 or 8 and TAG_W >= 1");
        end
    endgenerate

    // Rijndael row offsets; the wide block uses 0,1,3,4.
    function automatic int row_shift(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    logic [W-1:0]     fwd_state;
    logic [W-1:0]     inv_state;
    logic [W-1:0]     perm_state;

    always_comb begin
        fwd_state = '0;
        inv_state = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd_state[W-1-8*(4*c+r) -: 8] =
                    bus.in_state[W-1-8*(4*((c + row_shift(r)) % NB)+r) -: 8];
                inv_state[W-1-8*(4*c+r) -: 8] =
                    bus.in_state[W-1-8*(4*((c - row_shift(r) + NB) % NB)+r) -: 8];
            end
        end
    end

    assign perm_state = bus.in_inv ? inv_state : fwd_state;

    logic [W-1:0]     mem_state [2];
    logic [TAG_W-1:0] mem_tag   [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    assign bus.in_ready  = (cnt != 2'd2);
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.out_state = mem_state[rd_ptr];
    assign bus.out_tag   = mem_tag[rd_ptr];
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Entries are cleared on reset so the head reads as zero before any beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_state[0] <= '0;
            mem_state[1] <= '0;
            mem_tag[0]   <= '0;
            mem_tag[1]   <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            cnt          <= 2'd0;
        end else begin
            if (push) begin
                mem_state[wr_ptr] <= perm_state;
                mem_tag[wr_ptr]   <= bus.in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: row-rotation queue model plus literal FIPS-197 vectors.
module tb_shift_rows_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_rows_stream_if #(.NB(4), .TAG_W(4)) b4 ();
    shift_rows_stream_if #(.NB(6), .TAG_W(4)) b6 ();
    shift_rows_stream_if #(.NB(8), .TAG_W(4)) b8 ();

    shift_rows_stream #(.NB(4), .TAG_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    shift_rows_stream #(.NB(6), .TAG_W(4)) u_dut6 (.clk(clk), .rst(rst), .bus(b6));
    shift_rows_stream #(.NB(8), .TAG_W(4)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

    localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    typedef struct {
        logic [3:0]   tag;
        logic [127:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nerr  = 0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Rotate each row as a byte list: forward = rotate left by the row offset.
    function automatic logic [255:0] model(input logic [255:0] st, input int nb, input logic inv);
        logic [255:0] res;
        logic [7:0]   row[$];
        int           sh[4];
        sh  = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
        res = '0;
        for (int r = 0; r < 4; r++) begin
            row = {};
            for (int c = 0; c < nb; c++) row.push_back(st[32*nb-1-8*(4*c+r) -: 8]);
            repeat (sh[r]) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) res[32*nb-1-8*(4*c+r) -: 8] = row[c];
        end
        return res;
    endfunction

    // Record every accepted NB=4 beat with its expected result.
    always @(posedge clk) begin
        if (!rst && b4.in_valid && b4.in_ready) begin
            exp_t         e;
            logic [255:0] m;
            m       = model(256'(b4.in_state), 4, b4.in_inv);
            e.tag   = b4.in_tag;
            e.state = m[127:0];
            exp_q.push_back(e);
        end
    end

    // Per-cycle check of flags and head entry against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", 256'(b4.out_valid), 256'(exp_q.size() != 0));
            chk("in_ready", 256'(b4.in_ready), 256'(exp_q.size() < 2));
            if (b4.out_valid && exp_q.size() != 0) begin
                chk("head_state", 256'(b4.out_state), 256'(exp_q[0].state));
                chk("head_tag", 256'(b4.out_tag), 256'(exp_q[0].tag));
                if (b4.out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic inv, input logic [3:0] tag, input logic [127:0] st);
        int   waited;
        logic acc;
        waited      = 0;
        acc         = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_inv   = inv;
        b4.in_tag   = tag;
        b4.in_state = st;
        while (!acc && waited < 50) begin
            @(posedge clk);
            acc = b4.in_ready;
            waited++;
        end
        if (!acc) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: tag %0h not accepted after %0d cycles", tag, waited);
        end
        #1;
        b4.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] v6, o6;
        logic [255:0] v8, o8;
        int           base;

        b4.in_valid = 0; b4.in_inv = 0; b4.in_tag = '0; b4.in_state = '0; b4.out_ready = 1;
        b6.in_valid = 0; b6.in_inv = 0; b6.in_tag = '0; b6.in_state = '0; b6.out_ready = 1;
        b8.in_valid = 0; b8.in_inv = 0; b8.in_tag = '0; b8.in_state = '0; b8.out_ready = 1;

        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 256'(b4.out_valid), 256'(0));
        chk("rst_in_ready", 256'(b4.in_ready), 256'(1));
        chk("rst_out_state", 256'(b4.out_state), 256'(0));
        chk("rst_out_tag", 256'(b4.out_tag), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FIPS-197 round 1, forward then inverse
        send(1'b0, 4'h5, FIPS_IN);
        @(negedge clk);
        chk("fips_fwd_valid", 256'(b4.out_valid), 256'(1));
        chk("fips_fwd_state", 256'(b4.out_state), 256'(FIPS_OUT));
        chk("fips_fwd_tag", 256'(b4.out_tag), 256'(5));
        @(posedge clk); #1;
        send(1'b1, 4'h6, FIPS_OUT);
        @(negedge clk);
        chk("fips_inv_state", 256'(b4.out_state), 256'(FIPS_IN));
        chk("fips_inv_tag", 256'(b4.out_tag), 256'(6));
        @(posedge clk); #1;

        // Alternating modes back to back
        for (int i = 0; i < 8; i++) send(i[0], 4'(i), i[0] ? FIPS_OUT : FIPS_IN);
        repeat (3) @(posedge clk);
        #1;

        // Wider blocks with byte k = k
        for (int k = 0; k < 24; k++) v6[191-8*k -: 8] = 8'(k);
        for (int k = 0; k < 32; k++) v8[255-8*k -: 8] = 8'(k);
        b6.in_state = v6; b6.in_inv = 0; b6.in_valid = 1;
        b8.in_state = v8; b8.in_inv = 0; b8.in_valid = 1;
        @(posedge clk); #1;
        b6.in_valid = 0; b8.in_valid = 0;
        @(negedge clk);
        o6 = b6.out_state;
        o8 = b8.out_state;
        chk("nb6_valid", 256'(b6.out_valid), 256'(1));
        chk("nb6_col0", 256'(o6[191 -: 32]), 256'(32'h00050a0f));
        chk("nb6_fwd", 256'(o6), model(256'(v6), 6, 1'b0));
        chk("nb8_valid", 256'(b8.out_valid), 256'(1));
        chk("nb8_col0", 256'(o8[255 -: 32]), 256'(32'h00050e13));
        chk("nb8_col7", 256'(o8[31:0]), 256'(32'h1c010a0f));
        chk("nb8_fwd", o8, model(v8, 8, 1'b0));
        @(posedge clk); #1;
        b6.in_state = o6; b6.in_inv = 1; b6.in_valid = 1;
        b8.in_state = o8; b8.in_inv = 1; b8.in_valid = 1;
        @(posedge clk); #1;
        b6.in_valid = 0; b8.in_valid = 0;
        @(negedge clk);
        chk("nb6_roundtrip", 256'(b6.out_state), 256'(v6));
        chk("nb8_roundtrip", b8.out_state, v8);
        @(posedge clk); #1;

        // Backpressure: A and B held, C waits
        b4.out_ready = 0;
        base = n_out;
        send(1'b0, 4'h1, FIPS_IN);
        send(1'b1, 4'h2, FIPS_IN);
        b4.in_valid = 1; b4.in_inv = 0; b4.in_tag = 4'h3; b4.in_state = 128'h00112233_44556677_8899aabb_ccddeeff;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 256'(b4.in_ready), 256'(0));
            chk("stall_state", 256'(b4.out_state), 256'(FIPS_OUT));
            chk("stall_tag", 256'(b4.out_tag), 256'(1));
        end
        @(posedge clk); #1;
        b4.out_ready = 1;
        send(1'b0, 4'h3, 128'h00112233_44556677_8899aabb_ccddeeff);
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", 256'(n_out - base), 256'(3));

        // Sustained push and pop at occupancy 1
        base = n_out;
        for (int i = 0; i < 16; i++)
            send(i[0], 4'(i), {$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge clk);
        #1;
        chk("stream_count", 256'(n_out - base), 256'(16));

        // Asynchronous reset while full
        b4.out_ready = 0;
        send(1'b0, 4'h7, FIPS_IN);
        send(1'b0, 4'h8, FIPS_OUT);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 256'(b4.out_valid), 256'(0));
        chk("arst_in_ready", 256'(b4.in_ready), 256'(1));
        chk("arst_out_state", 256'(b4.out_state), 256'(0));
        chk("arst_out_tag", 256'(b4.out_tag), 256'(0));
        @(negedge clk); #1;
        rst = 1'b0;
        b4.out_ready = 1;
        send(1'b0, 4'h9, FIPS_IN);
        @(negedge clk);
        chk("post_rst_valid", 256'(b4.out_valid), 256'(1));
        chk("post_rst_state", 256'(b4.out_state), 256'(FIPS_OUT));
        chk("post_rst_tag", 256'(b4.out_tag), 256'(9));
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
